hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 15 +
 rtl/reg_scoreboard.sv | 41 ++++
 rtl/hazard_scoreboard.sv | 102 ++++++++++
 tb/tb_hazard_scoreboard.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the ID-stage hazard scoreboard.
package hazard_pkg;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_BEQ  = 3'd1,
        CLS_BNE  = 3'd2,
        CLS_J    = 3'd3,
        CLS_JR   = 3'd4
    } id_cls_t;

    localparam int DEFAULT_NREG    = 32;
    localparam int DEFAULT_MAX_LAT = 15;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register result-latency down-counters; register 0 never has a pending write.
module reg_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG    = DEFAULT_NREG,
    parameter int MAX_LAT = DEFAULT_MAX_LAT,
    localparam int LAT_W  = $clog2(MAX_LAT + 1),
    localparam int REG_W  = $clog2(NREG)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        hold,
    input  logic                        set_en,
    input  logic [REG_W-1:0]            set_idx,
    input  logic [LAT_W-1:0]            set_val,
    output logic [NREG-1:0][LAT_W-1:0]  cnt
);

    assign cnt[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_cnt
            logic [LAT_W-1:0] cnt_reg;

            // A new issue overrides the decrement of the same register.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (set_en && set_idx == REG_W'(gi)) begin
                    cnt_reg <= set_val;
                end else if (!hold && cnt_reg != '0) begin
                    cnt_reg <= cnt_reg - LAT_W'(1);
                end
            end

            assign cnt[gi] = cnt_reg;
        end
    endgenerate

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage interlock: RAW/WAW stalls, branch flushes, optional perf counters
// (enabled by defining HAZARD_PERF_CNT_EN).
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG    = DEFAULT_NREG,
    parameter int MAX_LAT = DEFAULT_MAX_LAT,
    localparam int LAT_W  = $clog2(MAX_LAT + 1),
    localparam int REG_W  = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [2:0]       id_cls,
    input  logic             id_eq,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_wr_en,
    input  logic [LAT_W-1:0] id_lat,
    input  logic             pipe_hold,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             ctrl_bubble,
    output logic             if_id_flush,
    output logic             id_issue,
    output logic [31:0]      perf_data_stall,
    output logic [31:0]      perf_flush
);

    logic [NREG-1:0][LAT_W-1:0] cnt;
    logic [LAT_W-1:0]           lat_clamped;
    logic                       resolves_in_id;
    logic                       rs_haz, rt_haz, waw_haz;
    logic                       data_stall;
    logic                       taken;
    logic                       set_en;

    assign lat_clamped = (id_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : id_lat;
    assign set_en      = id_issue && id_wr_en && id_dst != '0;

    reg_scoreboard #(
        .NREG    (NREG),
        .MAX_LAT (MAX_LAT)
    ) u_reg_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold    (pipe_hold),
        .set_en  (set_en),
        .set_idx (id_dst),
        .set_val (lat_clamped),
        .cnt     (cnt)
    );

    // Branches and JR read operands in ID, so they cannot use the EX bypass.
    always_comb begin
        resolves_in_id = (id_cls == CLS_BEQ) || (id_cls == CLS_BNE) || (id_cls == CLS_JR);
        taken          = (id_cls == CLS_J) || (id_cls == CLS_JR)
                       || ((id_cls == CLS_BEQ) && id_eq)
                       || ((id_cls == CLS_BNE) && !id_eq);
        rs_haz  = id_rs_used && id_rs != '0
                && (resolves_in_id ? (cnt[id_rs] != '0) : (cnt[id_rs] > LAT_W'(1)));
        rt_haz  = id_rt_used && id_rt != '0
                && (resolves_in_id ? (cnt[id_rt] != '0) : (cnt[id_rt] > LAT_W'(1)));
        waw_haz = id_wr_en && id_dst != '0 && (cnt[id_dst] > id_lat);
    end

    always_comb begin
        data_stall  = rst_n && id_valid && !pipe_hold && (rs_haz || rt_haz || waw_haz);
        pc_stall    = rst_n && (data_stall || pipe_hold);
        if_id_stall = pc_stall;
        ctrl_bubble = data_stall;
        id_issue    = rst_n && id_valid && !pipe_hold && !data_stall;
        if_id_flush = id_issue && taken;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_data_stall_reg;
    logic [31:0] perf_flush_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_data_stall_reg <= '0;
            perf_flush_reg      <= '0;
        end else if (!pipe_hold) begin
            if (data_stall && perf_data_stall_reg != '1)
                perf_data_stall_reg <= perf_data_stall_reg + 32'd1;
            if (if_id_flush && perf_flush_reg != '1)
                perf_flush_reg <= perf_flush_reg + 32'd1;
        end
    end

    assign perf_data_stall = perf_data_stall_reg;
    assign perf_flush      = perf_flush_reg;
`else
    assign perf_data_stall = '0;
    assign perf_flush      = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam logic [3:0] IDL = 4'b0000;  // {stall, bubble, flush, issue}
    localparam logic [3:0] ISS = 4'b0001;
    localparam logic [3:0] ISF = 4'b0011;
    localparam logic [3:0] STL = 4'b1100;
    localparam logic [3:0] HLD = 4'b1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [2:0]  id_cls = 3'd0;
    logic        id_eq = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_dst = '0;
    logic        id_rs_used = 1'b0, id_rt_used = 1'b0, id_wr_en = 1'b0;
    logic [3:0]  id_lat = '0;
    logic        pipe_hold = 1'b0;
    logic        pc_stall, if_id_stall, ctrl_bubble, if_id_flush, id_issue;
    logic [31:0] perf_data_stall, perf_flush;

    hazard_scoreboard dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_cls          (id_cls),
        .id_eq           (id_eq),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rs_used      (id_rs_used),
        .id_rt_used      (id_rt_used),
        .id_dst          (id_dst),
        .id_wr_en        (id_wr_en),
        .id_lat          (id_lat),
        .pipe_hold       (pipe_hold),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .ctrl_bubble     (ctrl_bubble),
        .if_id_flush     (if_id_flush),
        .id_issue        (id_issue),
        .perf_data_stall (perf_data_stall),
        .perf_flush      (perf_flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  ctl;
        logic        perf_known;
        logic [31:0] ps;
        logic [31:0] pf;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        perf_known = 1'b0;
    logic [31:0] ps_model = '0;
    logic [31:0] pf_model = '0;

    task automatic step(input string nm, input logic r, input logic h, input logic v,
                        input logic [2:0] c, input logic e,
                        input int rs, input logic ru, input int rt, input logic tu,
                        input int d, input logic w, input int l, input logic [3:0] x);
        exp_t ex;
        @(posedge clk);
        #1;
        rst_n = r; pipe_hold = h; id_valid = v; id_cls = c; id_eq = e;
        id_rs = rs[4:0]; id_rs_used = ru; id_rt = rt[4:0]; id_rt_used = tu;
        id_dst = d[4:0]; id_wr_en = w; id_lat = l[3:0];
        ex.name       = nm;
        ex.ctl        = {x[3], x[3], x[2], x[1], x[0]};
        ex.perf_known = perf_known;
        ex.ps         = ps_model;
        ex.pf         = pf_model;
        exp_q.push_back(ex);
        // Perf registers reflect every edge before the current cycle.
        if (!r) begin
            ps_model = '0; pf_model = '0; perf_known = 1'b1;
        end else begin
`ifdef HAZARD_PERF_CNT_EN
            if (x == STL) ps_model = ps_model + 32'd1;
            if (x[1])     pf_model = pf_model + 32'd1;
`endif
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t ex;
            logic [4:0] act;
            ex  = exp_q.pop_front();
            act = {pc_stall, if_id_stall, ctrl_bubble, if_id_flush, id_issue};
            checks++;
            if (act !== ex.ctl) begin
                errors++;
                $display("FAIL %s ctl {pc,ifid,bub,flush,issue} got %b want %b", ex.name, act, ex.ctl);
            end else begin
                $display("txn %s ctl=%b ps=%0d pf=%0d", ex.name, act, perf_data_stall, perf_flush);
            end
            if (ex.perf_known) begin
                checks++;
                if (perf_data_stall !== ex.ps || perf_flush !== ex.pf) begin
                    errors++;
                    $display("FAIL %s perf got %0d/%0d want %0d/%0d", ex.name,
                             perf_data_stall, perf_flush, ex.ps, ex.pf);
                end
            end
        end
    end

    initial begin
        //    name            r h v cls       e  rs ru rt tu  d  w lat exp
        step("rst0",          0,0,1,CLS_BEQ,  1, 8,1, 9,1,  8,1, 2, IDL);
        step("rst1",          0,1,1,CLS_J,    0, 0,0, 0,0,  0,0, 0, IDL);
        step("lw_r8",         1,0,1,CLS_NONE, 0, 1,1, 0,0,  8,1, 2, ISS);
        step("beq_r8_s1",     1,0,1,CLS_BEQ,  1, 8,1, 9,1,  0,0, 0, STL);
        step("beq_r8_s2",     1,0,1,CLS_BEQ,  1, 8,1, 9,1,  0,0, 0, STL);
        step("beq_r8_go",     1,0,1,CLS_BEQ,  1, 8,1, 9,1,  0,0, 0, ISF);
        step("add_r5",        1,0,1,CLS_NONE, 0, 2,1, 3,1,  5,1, 1, ISS);
        step("add_use_r5",    1,0,1,CLS_NONE, 0, 5,1, 0,0,  6,1, 1, ISS);
        step("add_r5_b",      1,0,1,CLS_NONE, 0, 2,1, 3,1,  5,1, 1, ISS);
        step("bne_r5_s1",     1,0,1,CLS_BNE,  0, 5,1, 0,1,  0,0, 0, STL);
        step("bne_r5_go",     1,0,1,CLS_BNE,  0, 5,1, 0,1,  0,0, 0, ISF);
        step("lw_r7",         1,0,1,CLS_NONE, 0, 0,0, 0,0,  7,1, 2, ISS);
        step("add_r7_s1",     1,0,1,CLS_NONE, 0, 0,0, 7,1, 11,1, 1, STL);
        step("add_r7_go",     1,0,1,CLS_NONE, 0, 0,0, 7,1, 11,1, 1, ISS);
        step("div_r10",       1,0,1,CLS_NONE, 0, 1,1, 2,1, 10,1,10, ISS);
        for (int i = 0; i < 9; i++)
            step($sformatf("waw_r10_s%0d", i), 1,0,1,CLS_NONE,0, 0,0,0,0, 10,1,1, STL);
        step("waw_r10_go",    1,0,1,CLS_NONE, 0, 0,0, 0,0, 10,1, 1, ISS);
        step("j_hold",        1,1,1,CLS_J,    0, 0,0, 0,0,  0,0, 0, HLD);
        step("j_go",          1,0,1,CLS_J,    0, 0,0, 0,0,  0,0, 0, ISF);
        step("lw_r12",        1,0,1,CLS_NONE, 0, 0,0, 0,0, 12,1, 2, ISS);
        step("beq_r12_h0",    1,1,1,CLS_BEQ,  0,12,1, 0,0,  0,0, 0, HLD);
        step("beq_r12_h1",    1,1,1,CLS_BEQ,  0,12,1, 0,0,  0,0, 0, HLD);
        step("beq_r12_s1",    1,0,1,CLS_BEQ,  0,12,1, 0,0,  0,0, 0, STL);
        step("beq_r12_s2",    1,0,1,CLS_BEQ,  0,12,1, 0,0,  0,0, 0, STL);
        step("beq_r12_go",    1,0,1,CLS_BEQ,  0,12,1, 0,0,  0,0, 0, ISS);
        step("wr_r0",         1,0,1,CLS_NONE, 0, 0,0, 0,0,  0,1, 5, ISS);
        step("beq_r0",        1,0,1,CLS_BEQ,  1, 0,1, 0,1,  0,0, 0, ISF);
        step("add_r8",        1,0,1,CLS_NONE, 0, 0,0, 0,0,  8,1, 1, ISS);
        step("jr_r8_s1",      1,0,1,CLS_JR,   0, 8,1, 0,0,  0,0, 0, STL);
        step("jr_r8_go",      1,0,1,CLS_JR,   0, 8,1, 0,0,  0,0, 0, ISF);
        step("lw_r13",        1,0,1,CLS_NONE, 0, 0,0, 0,0, 13,1, 2, ISS);
        step("unused_r13",    1,0,1,CLS_NONE, 0,13,0,13,0,  0,0, 0, ISS);
        step("bubble",        1,0,0,CLS_BEQ,  1, 0,0, 0,0,  0,0, 0, IDL);
        step("lat0_r16",      1,0,1,CLS_NONE, 0, 0,0, 0,0, 16,1, 0, ISS);
        step("use_r16",       1,0,1,CLS_BEQ,  0,16,1, 0,0,  0,0, 0, ISS);
        step("mul_r14",       1,0,1,CLS_NONE, 0, 0,0, 0,0, 14,1,12, ISS);
        step("add_r14_s",     1,0,1,CLS_NONE, 0,14,1, 0,0, 15,1, 1, STL);
        step("rst_mid",       0,0,1,CLS_NONE, 0,14,1, 0,0, 15,1, 1, IDL);
        step("add_r14_go",    1,0,1,CLS_NONE, 0,14,1, 0,0, 15,1, 1, ISS);
        step("idle_end",      1,0,0,CLS_NONE, 0, 0,0, 0,0,  0,0, 0, IDL);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
